load_store_unit: RTL and testbench

Load/store unit: the initiator that drives the byte-addressed, little-endian data memory on behalf of the core's execute stage. Accepts one load or store per valid/ready handshake and issues the memory access with the correct store size. Waits out the memory's one-cycle synchronous read, then returns a byte/half/word result that is sign- or zero-extended per RV32I funct3. Sits between the execute stage and the data memory.

---
 rtl/lsu_pkg.sv | 50 +++++
 rtl/load_store_unit_if.sv | 38 +++
 rtl/lsu_load_align.sv | 21 ++
 rtl/load_store_unit.sv | 135 +++++++++++++
 tb/tb_load_store_unit.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: RV32I funct3 encodings,
// memory store sizes, FSM states and the captured request record.
package lsu_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned F3_WIDTH = 3;
    localparam int unsigned RD_WIDTH = 5;

    localparam logic [F3_WIDTH-1:0] F3_B  = 3'b000;
    localparam logic [F3_WIDTH-1:0] F3_H  = 3'b001;
    localparam logic [F3_WIDTH-1:0] F3_W  = 3'b010;
    localparam logic [F3_WIDTH-1:0] F3_BU = 3'b100;
    localparam logic [F3_WIDTH-1:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } store_size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        DONE  = 2'b10
    } state_e;

    // Fields of an accepted request that must survive until the response.
    typedef struct packed {
        logic                we;
        logic [F3_WIDTH-1:0] funct3;
        logic [RD_WIDTH-1:0] rd;
        logic                fault;
    } req_info_t;

    function automatic logic f3_legal(input logic we, input logic [F3_WIDTH-1:0] f3);
        if (we) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic [2:0] access_bytes(input logic [F3_WIDTH-1:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-stage request/response and data-memory signals of the load/store unit.
// slave = the unit itself; master = its environment (requester and memory).
interface load_store_unit_if;
    import lsu_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [F3_WIDTH-1:0] req_funct3;
    logic [XLEN-1:0]     req_addr;
    logic [XLEN-1:0]     req_wdata;
    logic [RD_WIDTH-1:0] req_rd;

    logic                resp_valid;
    logic [XLEN-1:0]     resp_rdata;
    logic [RD_WIDTH-1:0] resp_rd;
    logic                resp_fault;

    logic                mem_write_en;
    logic                mem_read_en;
    logic [XLEN-1:0]     mem_addr;
    logic [1:0]          mem_store_size;
    logic [XLEN-1:0]     mem_write_data;
    logic [XLEN-1:0]     mem_read_data;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_rd, resp_fault,
        output mem_write_en, mem_read_en, mem_addr, mem_store_size, mem_write_data
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_rd, resp_fault,
        input  mem_write_en, mem_read_en, mem_addr, mem_store_size, mem_write_data
    );

endinterface

// File: rtl/lsu_load_align.sv
// Sign/zero extension of the memory read word according to the load funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [F3_WIDTH-1:0] funct3_i,
    input  logic [XLEN-1:0]     rdata_i,
    output logic [XLEN-1:0]     data_c_o
);

    always_comb begin
        data_c_o = rdata_i;
        case (funct3_i)
            F3_B:    data_c_o = {{24{rdata_i[7]}}, rdata_i[7:0]};
            F3_BU:   data_c_o = {24'b0, rdata_i[7:0]};
            F3_H:    data_c_o = {{16{rdata_i[15]}}, rdata_i[15:0]};
            F3_HU:   data_c_o = {16'b0, rdata_i[15:0]};
            default: data_c_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one access per handshake, IDLE -> ISSUE -> DONE -> IDLE.
// Define LSU_ALIGN_CHECK_EN to also fault misaligned and out-of-range accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_SIZE = 512
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);

`ifdef LSU_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    state_e              state_q, state_d;
    req_info_t           info_q, info_d;
    logic                mem_we_q, mem_we_d;
    logic                mem_re_q, mem_re_d;
    logic [XLEN-1:0]     mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]     mem_wdata_q, mem_wdata_d;
    store_size_e         mem_size_q, mem_size_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_fault_q, resp_fault_d;
    logic [RD_WIDTH-1:0] resp_rd_q, resp_rd_d;

    logic                ready_c;
    logic                accept_c;
    logic                fault_c;
    logic                misalign_c;
    logic                range_c;
    logic [2:0]          nbytes_c;
    logic [XLEN:0]       end_addr_c;
    logic [XLEN-1:0]     load_data_c;

    assign ready_c  = (state_q == IDLE) && !rst;
    assign accept_c = bus.req_valid && ready_c;

    // Fault classification of the incoming request.
    always_comb begin
        nbytes_c   = access_bytes(bus.req_funct3);
        end_addr_c = {1'b0, bus.req_addr} + 33'(nbytes_c);
        misalign_c = ((nbytes_c == 3'd2) && bus.req_addr[0]) ||
                     ((nbytes_c == 3'd4) && (bus.req_addr[1:0] != 2'b00));
        range_c    = end_addr_c > 33'(MEM_SIZE);
        fault_c    = !f3_legal(bus.req_we, bus.req_funct3) ||
                     (ALIGN_CHECK && (misalign_c || range_c));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            info_q       <= '0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_size_q   <= SZ_BYTE;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rd_q    <= '0;
        end else begin
            state_q      <= state_d;
            info_q       <= info_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_size_q   <= mem_size_d;
            resp_valid_q <= resp_valid_d;
            resp_fault_q <= resp_fault_d;
            resp_rd_q    <= resp_rd_d;
        end
    end

    // Memory and response registers are loaded on entry to the state that shows them.
    always_comb begin
        state_d      = state_q;
        info_d       = info_q;
        mem_we_d     = 1'b0;
        mem_re_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        mem_size_d   = SZ_BYTE;
        resp_valid_d = 1'b0;
        resp_fault_d = 1'b0;
        resp_rd_d    = '0;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = ISSUE;
                    info_d  = '{we: bus.req_we, funct3: bus.req_funct3,
                                rd: bus.req_rd, fault: fault_c};
                    if (!fault_c) begin
                        mem_we_d    = bus.req_we;
                        mem_re_d    = !bus.req_we;
                        mem_addr_d  = bus.req_addr;
                        mem_wdata_d = bus.req_wdata;
                        mem_size_d  = store_size_e'(bus.req_funct3[1:0]);
                    end
                end
            end
            ISSUE: begin
                state_d      = DONE;
                resp_valid_d = 1'b1;
                resp_fault_d = info_q.fault;
                resp_rd_d    = info_q.rd;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    lsu_load_align u_load_align (
        .funct3_i (info_q.funct3),
        .rdata_i  (bus.mem_read_data),
        .data_c_o (load_data_c)
    );

    // Read data arrives during DONE, so the extended result is presented combinationally.
    assign bus.req_ready      = ready_c;
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_fault     = resp_fault_q;
    assign bus.resp_rd        = resp_rd_q;
    assign bus.resp_rdata     = (resp_valid_q && !info_q.we && !info_q.fault) ? load_data_c : '0;
    assign bus.mem_write_en   = mem_we_q && !rst;
    assign bus.mem_read_en    = mem_re_q && !rst;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_store_size = mem_size_q;
    assign bus.mem_write_data = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array data memory, reference model of the
// architectural memory contents and response timing, plus literal expectations.
module tb_load_store_unit;

    localparam int unsigned MEM_BYTES = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if ifc();

    load_store_unit #(.MEM_SIZE(MEM_BYTES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit started = 1'b0;

    logic [7:0]  dmem    [MEM_BYTES];
    logic [7:0]  ref_mem [MEM_BYTES];
    logic [31:0] rd_word;

    typedef struct {
        bit          chk;
        logic [31:0] data;
        bit          fault;
    } lit_t;
    lit_t lit_q[$];

    typedef struct {
        bit          we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        bit          fault;
        int          acc;
    } txn_t;
    txn_t cur;
    bit   busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Data memory: synchronous write, read data valid the cycle after mem_read_en.
    always @(posedge clk) begin
        if (ifc.mem_write_en) begin
            for (int i = 0; i < 4; i++) begin
                if (i < (1 << ifc.mem_store_size))
                    dmem[9'(ifc.mem_addr + 32'(i))] <= ifc.mem_write_data[8*i +: 8];
            end
        end
        if (ifc.mem_read_en) begin
            for (int i = 0; i < 4; i++) rd_word[8*i +: 8] = dmem[9'(ifc.mem_addr + 32'(i))];
            ifc.mem_read_data <= rd_word;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit model_fault(input bit we, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
`ifdef LSU_ALIGN_CHECK_EN
        if ((longint'(a) % nbytes(f3)) != 0) return 1'b1;
        if (longint'(a) + nbytes(f3) > longint'(MEM_BYTES)) return 1'b1;
`endif
        return !legal;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        longint v = 0;
        int     n = nbytes(f3);
        for (int i = 0; i < n; i++) v += longint'(ref_mem[9'(a + 32'(i))]) << (8 * i);
        if (f3[2] == 1'b0 && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v -= (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        for (int i = 0; i < nbytes(f3); i++) ref_mem[9'(a + 32'(i))] = wd[8*i +: 8];
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin : mon
        int          ph;
        bit          e_ready, e_we, e_re, e_rv;
        logic [31:0] e_addr, e_wd, e_data;
        logic [1:0]  e_sz;
        lit_t        lit;
        if (started) begin
            ph      = busy ? (cyc - cur.acc) : 0;
            e_ready = !rst && !busy;
            e_we = 1'b0; e_re = 1'b0; e_rv = 1'b0;
            e_addr = '0; e_wd = '0; e_sz = 2'b00;
            if (busy && ph == 1 && !cur.fault) begin
                e_we   = !rst && cur.we;
                e_re   = !rst && !cur.we;
                e_addr = cur.addr;
                e_wd   = cur.wdata;
                e_sz   = cur.f3[1:0];
                if (!rst && cur.we) model_store(cur.f3, cur.addr, cur.wdata);
            end
            chk("req_ready", 32'(ifc.req_ready), 32'(e_ready));
            chk("mem_write_en", 32'(ifc.mem_write_en), 32'(e_we));
            chk("mem_read_en", 32'(ifc.mem_read_en), 32'(e_re));
            chk("mem_addr", ifc.mem_addr, e_addr);
            chk("mem_write_data", ifc.mem_write_data, e_wd);
            chk("mem_store_size", 32'(ifc.mem_store_size), 32'(e_sz));
            if (busy && ph == 2 && !rst) begin
                e_rv   = 1'b1;
                e_data = (cur.we || cur.fault) ? 32'h0 : model_load(cur.f3, cur.addr);
                chk("resp_rd", 32'(ifc.resp_rd), 32'(cur.rd));
                chk("resp_fault", 32'(ifc.resp_fault), 32'(cur.fault));
                chk("resp_rdata", ifc.resp_rdata, e_data);
                if (lit_q.size() > 0) begin
                    lit = lit_q.pop_front();
                    if (lit.chk) begin
                        chk("lit_rdata", ifc.resp_rdata, lit.data);
                        chk("lit_fault", 32'(ifc.resp_fault), 32'(lit.fault));
                    end
                end
            end
            if (!(rst && busy && ph == 2)) chk("resp_valid", 32'(ifc.resp_valid), 32'(e_rv));
            if (busy && ph >= 2) busy = 1'b0;
            if (rst) busy = 1'b0;
            if (e_ready && ifc.req_valid) begin
                cur = '{we: ifc.req_we, f3: ifc.req_funct3, addr: ifc.req_addr,
                        wdata: ifc.req_wdata, rd: ifc.req_rd,
                        fault: model_fault(ifc.req_we, ifc.req_funct3, ifc.req_addr), acc: cyc};
                busy = 1'b1;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd, input bit push,
                        input logic [31:0] exp_data, input bit exp_fault);
        bit ok = 1'b0;
        if (push) lit_q.push_back('{chk: 1'b1, data: exp_data, fault: exp_fault});
        ifc.req_we = we; ifc.req_funct3 = f3; ifc.req_addr = a;
        ifc.req_wdata = wd; ifc.req_rd = rd; ifc.req_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (ifc.req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout at cycle %0d: req_ready stayed 0, required 1", cyc);
        end
        @(posedge clk);
        #1;
        ifc.req_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < int'(MEM_BYTES); i++) begin
            dmem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        ifc.req_valid = 1'b0; ifc.req_we = 1'b0; ifc.req_funct3 = 3'b000;
        ifc.req_addr = '0; ifc.req_wdata = '0; ifc.req_rd = '0;
        ifc.mem_read_data = '0;
        rst = 1'b1;
        @(posedge clk);
        started = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 32'(ifc.req_ready), 32'h0);
        chk("reset_resp_valid", 32'(ifc.resp_valid), 32'h0);
        chk("reset_mem_read_en", 32'(ifc.mem_read_en), 32'h0);
        chk("reset_resp_rdata", ifc.resp_rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(ifc.req_ready), 32'h1);
        @(posedge clk); #1;

        send(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd1, 1'b1, 32'h0, 1'b0);
        send(1'b0, 3'b010, 32'h10, 32'h0, 5'd2, 1'b1, 32'hDEADBEEF, 1'b0);
        send(1'b0, 3'b000, 32'h13, 32'h0, 5'd3, 1'b1, 32'hFFFFFFDE, 1'b0);
        send(1'b0, 3'b100, 32'h13, 32'h0, 5'd4, 1'b1, 32'h000000DE, 1'b0);
        send(1'b0, 3'b001, 32'h12, 32'h0, 5'd5, 1'b1, 32'hFFFFDEAD, 1'b0);
        send(1'b0, 3'b101, 32'h10, 32'h0, 5'd6, 1'b1, 32'h0000BEEF, 1'b0);
        send(1'b1, 3'b000, 32'h10, 32'h12345678, 5'd7, 1'b1, 32'h0, 1'b0);
        send(1'b0, 3'b010, 32'h10, 32'h0, 5'd8, 1'b1, 32'hDEADBE78, 1'b0);
        send(1'b1, 3'b001, 32'h12, 32'hAAAA5555, 5'd9, 1'b1, 32'h0, 1'b0);
        send(1'b0, 3'b010, 32'h10, 32'h0, 5'd10, 1'b1, 32'h5555BE78, 1'b0);
`ifdef LSU_ALIGN_CHECK_EN
        send(1'b0, 3'b010, 32'h11, 32'h0, 5'd11, 1'b1, 32'h0, 1'b1);
`else
        send(1'b0, 3'b010, 32'h11, 32'h0, 5'd11, 1'b1, 32'h005555BE, 1'b0);
`endif
        send(1'b0, 3'b011, 32'h10, 32'h0, 5'd12, 1'b1, 32'h0, 1'b1);
        send(1'b1, 3'b100, 32'h20, 32'h0000FFFF, 5'd13, 1'b1, 32'h0, 1'b1);
        send(1'b1, 3'b000, 32'h1FF, 32'h000000A5, 5'd14, 1'b1, 32'h0, 1'b0);
        send(1'b0, 3'b000, 32'h1FF, 32'h0, 5'd15, 1'b1, 32'hFFFFFFA5, 1'b0);
`ifdef LSU_ALIGN_CHECK_EN
        send(1'b0, 3'b010, 32'h1FE, 32'h0, 5'd16, 1'b1, 32'h0, 1'b1);
`else
        send(1'b0, 3'b010, 32'h1FE, 32'h0, 5'd16, 1'b1, 32'h0000A500, 1'b0);
`endif
        send(1'b0, 3'b010, 32'h1FC, 32'h0, 5'd17, 1'b1, 32'hA5000000, 1'b0);

        // Reset during the ISSUE cycle of a load aborts it.
        repeat (3) @(posedge clk);
        #1;
        send(1'b0, 3'b010, 32'h10, 32'h0, 5'd18, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_abort", 32'(ifc.req_ready), 32'h1);
        chk("no_resp_after_abort", 32'(ifc.resp_valid), 32'h0);
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        send(1'b0, 3'b010, 32'h10, 32'h0, 5'd19, 1'b1, 32'h5555BE78, 1'b0);

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("pending_responses", 32'(lit_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
